// File: rtl/light_selector_multi_if.sv
// Front-panel bundle for light_selector_multi: per-channel button/sel, global mode,
// and the RGB word plus wrap pulses that go on to the LED driver.
interface light_selector_multi_if #(
   parameter int CHANNELS = 4,
   parameter int COMP_W   = 8
) ();
   logic [CHANNELS-1:0]            button;
   logic [CHANNELS-1:0]            sel;
   logic [1:0]                     mode;
   logic [CHANNELS*3*COMP_W-1:0]   light;
   logic [CHANNELS-1:0]            wrap;

   modport master (output button, output sel, output mode, input light, input wrap);
   modport slave  (input button, input sel, input mode, output light, output wrap);
endinterface

// File: rtl/light_selector_multi.sv
// Multi-channel colour stepper: each channel walks a 3-bit colour code on button
// edges or auto ticks and presents it as a registered RGB word (white when deselected).
module light_selector_multi #(
   parameter int CHANNELS = 4,
   parameter int COMP_W   = 8,
   parameter int AUTO_DIV = 16,
   parameter int SKIP_BW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   light_selector_multi_if.slave   bus
);
   localparam int              PW    = $clog2(AUTO_DIV);
   localparam int              LW    = 3 * COMP_W;
   localparam logic [2:0]      FIRST = (SKIP_BW != 0) ? 3'b001 : 3'b000;
   localparam logic [2:0]      LAST  = (SKIP_BW != 0) ? 3'b110 : 3'b111;
   localparam logic [PW-1:0]   PMAX  = PW'(AUTO_DIV - 1);

   logic [2:0]             colour_q [CHANNELS];
   logic [2:0]             colour_d [CHANNELS];
   logic [CHANNELS-1:0]    button_q, button_d;
   logic [CHANNELS-1:0]    wrap_q, wrap_d;
   logic [PW-1:0]          presc_q, presc_d;
   logic [CHANNELS*LW-1:0] light_q, light_d;

   logic                   tick_s;
   logic                   rev_s;
   logic [CHANNELS-1:0]    edge_s;
   logic [CHANNELS-1:0]    step_s;

   // Mode decode: prescaler, edge detect and per-channel step requests.
   always_comb begin
      tick_s   = 1'b0;
      rev_s    = 1'b0;
      presc_d  = '0;
      step_s   = '0;
      button_d = bus.button;
      edge_s   = bus.button & ~button_q;
      if (bus.mode[1]) begin
         tick_s  = (presc_q == PMAX);
         presc_d = tick_s ? '0 : presc_q + PW'(1);
      end else begin
         presc_d = '0;
      end
      // Ticks only advance selected channels; a button edge always counts once.
      case (bus.mode)
         2'b00:   step_s = '0;
         2'b01:   step_s = edge_s;
         2'b10:   step_s = edge_s | ({CHANNELS{tick_s}} & bus.sel);
         2'b11: begin
            step_s = edge_s | ({CHANNELS{tick_s}} & bus.sel);
            rev_s  = 1'b1;
         end
         default: step_s = '0;
      endcase
   end

   // Per-channel colour stepping, wrap detection and RGB expansion of the current code.
   always_comb begin
      wrap_d  = '0;
      light_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         colour_d[i] = colour_q[i];
         if (step_s[i]) begin
            if (rev_s) begin
               if (colour_q[i] == FIRST) begin
                  colour_d[i] = LAST;
                  wrap_d[i]   = 1'b1;
               end else begin
                  colour_d[i] = colour_q[i] - 3'd1;
               end
            end else begin
               if (colour_q[i] == LAST) begin
                  colour_d[i] = FIRST;
                  wrap_d[i]   = 1'b1;
               end else begin
                  colour_d[i] = colour_q[i] + 3'd1;
               end
            end
         end else begin
            colour_d[i] = colour_q[i];
         end
         if (bus.sel[i]) begin
            light_d[i*LW +: LW] = {{COMP_W{colour_q[i][2]}},
                                   {COMP_W{colour_q[i][1]}},
                                   {COMP_W{colour_q[i][0]}}};
         end else begin
            light_d[i*LW +: LW] = '1;
         end
      end
   end

   // State and output registers; button_q resets high so a held button does not step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            colour_q[i] <= FIRST;
         end
         button_q <= '1;
         wrap_q   <= '0;
         presc_q  <= '0;
         light_q  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            colour_q[i] <= colour_d[i];
         end
         button_q <= button_d;
         wrap_q   <= wrap_d;
         presc_q  <= presc_d;
         light_q  <= light_d;
      end
   end

   assign bus.light = light_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_light_selector_multi.sv
// Directed bench for light_selector_multi (2 channels, 8-bit components, AUTO_DIV=4):
// stimulus pushes hand-computed light/wrap values, a negedge monitor pops and compares.
module tb_light_selector_multi;
   localparam logic [23:0] C1 = 24'h0000FF;
   localparam logic [23:0] C2 = 24'h00FF00;
   localparam logic [23:0] C3 = 24'h00FFFF;
   localparam logic [23:0] C4 = 24'hFF0000;
   localparam logic [23:0] C5 = 24'hFF00FF;
   localparam logic [23:0] C6 = 24'hFFFF00;
   localparam logic [23:0] WH = 24'hFFFFFF;

   typedef struct {
      logic [47:0] l;
      logic [1:0]  w;
      int          id;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   exp_t  sbq [$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    vec_id = 0;
   logic [23:0] fwd_seq [6];
   logic [23:0] man_old [3];
   logic [23:0] man_new [3];
   logic [23:0] prev;
   logic [23:0] ch0;

   light_selector_multi_if #(.CHANNELS(2), .COMP_W(8)) bus ();

   light_selector_multi #(
      .CHANNELS(2), .COMP_W(8), .AUTO_DIV(4), .SKIP_BW(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, then queue what the outputs must be after that edge.
   task automatic cyc(input logic [1:0] b, input logic [1:0] s, input logic [1:0] m,
                      input logic [47:0] el, input logic [1:0] ew);
      exp_t e;
      bus.button = b;
      bus.sel    = s;
      bus.mode   = m;
      @(posedge clk);
      #1;
      e.l  = el;
      e.w  = ew;
      e.id = vec_id;
      vec_id++;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_cmp++;
         if (bus.light !== e.l || bus.wrap !== e.w) begin
            n_err++;
            $display("FAIL vec%0d: light=%h wrap=%b, expected light=%h wrap=%b",
                     e.id, bus.light, bus.wrap, e.l, e.w);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fwd_seq = '{C2, C3, C4, C5, C6, C1};
      man_old = '{C4, C5, C6};
      man_new = '{C5, C6, C1};
      rst        = 1'b0;
      bus.button = 2'b00;
      bus.sel    = 2'b11;
      bus.mode   = 2'b01;

      // Reset state, then first edge loads FIRST colour on both channels.
      cyc(2'b00, 2'b11, 2'b01, 48'h0, 2'b00);
      cyc(2'b00, 2'b11, 2'b01, 48'h0, 2'b00);
      rst = 1'b1;
      cyc(2'b00, 2'b11, 2'b01, {C1, C1}, 2'b00);

      // Manual stepping of ch0 through the full sequence, wrapping on the last step.
      prev = C1;
      for (int i = 0; i < 6; i++) begin
         cyc(2'b01, 2'b11, 2'b01, {C1, prev}, (i == 5) ? 2'b01 : 2'b00);
         cyc(2'b00, 2'b11, 2'b01, {C1, fwd_seq[i]}, 2'b00);
         prev = fwd_seq[i];
      end

      // Auto-forward, ch1 deselected; button pulse coincides with the tick at cycle 8.
      for (int e = 1; e <= 13; e++) begin
         ch0 = (e <= 4) ? C1 : (e <= 8) ? C2 : (e <= 12) ? C3 : C4;
         cyc((e == 8) ? 2'b01 : 2'b00, 2'b01, 2'b10, {WH, ch0}, 2'b00);
      end

      // Back to manual: walk ch0 from 100 to 001, clearing the prescaler on the way.
      for (int i = 0; i < 3; i++) begin
         cyc(2'b01, 2'b11, 2'b01, {C1, man_old[i]}, (i == 2) ? 2'b01 : 2'b00);
         cyc(2'b00, 2'b11, 2'b01, {C1, man_new[i]}, 2'b00);
      end

      // Auto-reverse from 001: first tick wraps to 110, second goes to 101.
      for (int f = 1; f <= 9; f++) begin
         ch0 = (f <= 4) ? C1 : (f <= 8) ? C6 : C5;
         cyc(2'b00, 2'b01, 2'b11, {WH, ch0}, (f == 4) ? 2'b01 : 2'b00);
      end

      // Hold mode ignores edges and nothing is deferred into manual mode.
      for (int g = 1; g <= 4; g++) begin
         cyc((g % 2 == 1) ? 2'b11 : 2'b00, 2'b11, 2'b00, {C1, C5}, 2'b00);
      end
      cyc(2'b00, 2'b11, 2'b01, {C1, C5}, 2'b00);
      cyc(2'b00, 2'b11, 2'b01, {C1, C5}, 2'b00);

      // Mid-cycle reset with button[1] held: no step on release.
      bus.button = 2'b10;
      #2;
      rst = 1'b0;
      cyc(2'b10, 2'b11, 2'b01, 48'h0, 2'b00);
      cyc(2'b10, 2'b11, 2'b01, 48'h0, 2'b00);
      rst = 1'b1;
      cyc(2'b10, 2'b11, 2'b01, {C1, C1}, 2'b00);
      cyc(2'b10, 2'b11, 2'b01, {C1, C1}, 2'b00);
      cyc(2'b00, 2'b11, 2'b01, {C1, C1}, 2'b00);

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/light_selector_multi.md
Name: light_selector_multi

Overview:
- Parametrised, multi-channel successor to the single-channel lights selector.
- Each channel holds a 3-bit colour code. The code steps on a button rising edge or on an automatic timer tick.
- The code is expanded to a 3*COMP_W-bit RGB word, or forced to white when the channel's sel is low.
- Sits between the debounced front-panel inputs and the LED driver block.

Parameters:
CHANNELS, 4, number of independent light channels (1..16)
COMP_W, 8, bits per colour component (R, G, B each COMP_W wide)
AUTO_DIV, 16, clock cycles per auto-mode step (>=2)
SKIP_BW, 1, 1: sequence 001..110 (skip black/white); 0: sequence 000..111

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
button  in  CHANNELS  per-channel step request, level; rising edge = one step
sel  in  CHANNELS  per-channel: 1 = show colour, 0 = force white
mode  in  2  global: 00 hold, 01 manual, 10 auto-forward, 11 auto-reverse
light  out  CHANNELS*3*COMP_W  channel i occupies bits [(i+1)*3*COMP_W-1 : i*3*COMP_W], ordered R,G,B from MSB
wrap  out  CHANNELS  one-cycle pulse per channel when its colour sequence wraps

Behaviour:
- Reset (rst low, async): colour[i] = FIRST (001 if SKIP_BW else 000); light = 0; wrap = 0; prescaler = 0; button_q = all ones.
  - Because button_q resets high, a button held across reset release causes no step.
- FIRST/LAST: 001/110 when SKIP_BW=1, 000/111 when SKIP_BW=0.
- Edge detect: edge[i] = button[i] & ~button_q[i]. button_q <= button every cycle, in all modes.
- Prescaler:
  - Counts 0..AUTO_DIV-1 only in modes 10/11; held at 0 in modes 00/01.
  - tick = (mode[1] & prescaler == AUTO_DIV-1). The counter wraps to 0 on tick.
  - A mode change out of auto clears the prescaler the next edge.
- Step request per channel:
  - mode 00: never; edges are discarded, not queued.
  - mode 01: step forward on edge[i].
  - mode 10: step forward on (tick | edge[i]).
  - mode 11: step reverse on (tick | edge[i]).
  - tick and edge in the same cycle give exactly one step.
  - Auto ticks step only channels with sel[i]=1. Button edges step regardless of sel.
- Step arithmetic (3-bit, no other states reachable):
  - Forward: LAST -> FIRST, else +1.
  - Reverse: FIRST -> LAST, else -1.
- Colour register updates on the same clock edge at which the edge/tick is seen.
- wrap[i]: registered, high for exactly one cycle. It is set on the edge where colour[i] goes LAST->FIRST (forward) or FIRST->LAST (reverse), otherwise 0.
- light (registered, updated every edge):
  - sel[i]=1: R = {COMP_W{colour[2]}}, G = {COMP_W{colour[1]}}, B = {COMP_W{colour[0]}}, computed from the pre-update colour value.
  - sel[i]=0: all ones.
- Latency:
  - button rise sampled at edge k -> colour at edge k -> light at edge k+1.
  - sel change sampled at edge k -> light at edge k.
- Reset mid-operation: all state returns to reset values immediately. The first post-reset edge loads light from FIRST/sel.

Test Plan (CHANNELS=2, COMP_W=8, AUTO_DIV=4, SKIP_BW=1):
1. Reset, mode=01, sel=11, no buttons -> after first edge light = 48'h0000FF_0000FF, wrap = 00.
2. mode=01, six single-cycle pulses on button[0] -> ch0 light sequence 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, 0000FF. wrap[0] pulses once on the 110->001 step; ch1 stays 0000FF.
3. mode=10, sel=01 -> ch0 steps every 4 clocks (prescaler 3). ch1 holds its colour and shows FFFFFF. Pulsing button[0] on the tick cycle yields one step only.
4. mode=11 from colour 001 -> next tick gives 110 (FFFF00) and a one-cycle wrap pulse.
5. mode=00, toggle both buttons repeatedly, then switch to mode=01 with buttons low -> colours unchanged, no deferred step.
6. Hold button[1] high, assert rst low mid-cycle, then release -> light = 0 during reset. No step after release. First edge light = 0000FF_0000FF.
